parametric_number_analyzer: RTL
===============================

// Module: parametric_number_analyzer
// PURPOSE
// - Multi-cycle classifier for WIDTH-bit unsigned numbers; second-generation number analyzer.
// - Reports odd/even, remainder modulo MODULUS and divisible-by-MODULUS for each accepted number.
// - Sits between a valid/ready number source and a valid/ready result consumer.
// - Computes the remainder serially, one bit per cycle, MSB first; no divider is inferred.
// PARAMETERS
// - WIDTH    8  bit width of in_number; >= 1.
// - MODULUS  3  divisor for the remainder and divisibility test; >= 2.
// - RW       $clog2(MODULUS)  localparam, remainder width; not user-overridable.
// PORTS
// - clock         in   1      system clock, rising-edge.
// - reset         in   1      asynchronous, active-high; returns the block to IDLE.
// - enable        in   1      0 = abort the current operation and hold IDLE; 1 = run.
// - in_valid      in   1      in_number is valid this cycle.
// - in_ready      out  1      block can accept a number; = enable && state==IDLE (combinational).
// - in_number     in   WIDTH  unsigned number to analyze.
// - out_valid     out  1      result outputs are valid.
// - out_ready     in   1      consumer accepts the result.
// - is_odd        out  1      LSB of the accepted number.
// - is_divisible  out  1      1 iff remainder == 0.
// - remainder     out  RW     in_number mod MODULUS.
// BEHAVIOUR
// - States: IDLE, SHIFT, DONE. Reset values: state IDLE, out_valid 0, is_odd 0, is_divisible 0,
//   remainder 0, shift register 0, counter 0.
// - IDLE: on an edge with in_valid && in_ready:
//   - capture in_number into the shift register and is_odd <= in_number[0];
//   - clear the running remainder r <= 0; count <= WIDTH; go to SHIFT.
// - SHIFT: each edge computes t = 2*r + shreg[WIDTH-1], then r <= (t >= MODULUS) ? t - MODULUS : t.
//   - One conditional subtract suffices because r < MODULUS.
//   - Shift left by 1 and decrement count; when count == 1 this is the last bit -> DONE.
//   - The t computation is RW+1 bits wide; no overflow is possible.
// - DONE: out_valid = 1; remainder = r and is_divisible = (r == 0), both registered.
//   - On an edge with out_ready = 1, out_valid drops and the block goes to IDLE.
// - Latency: acceptance at edge E0 -> out_valid high after edge E0+WIDTH. A result held in DONE
//   stays stable until the handshake; out_ready may stay high continuously.
// - Throughput: at most 1 number per WIDTH+2 cycles (in_ready is low during SHIFT and DONE).
// - enable = 0 on any edge (synchronous abort): state <= IDLE, out_valid <= 0.
//   - is_odd, remainder and is_divisible keep their last values and are meaningless while
//     out_valid = 0.
//   - An in-flight number is discarded and never reported. in_ready = 0 while enable = 0.
// - Reset asserted mid-SHIFT or mid-DONE: immediate return to IDLE with the reset values above;
//   no partial result is ever presented.
// - in_valid in SHIFT/DONE is ignored (no capture); the source must hold it until in_ready.
// - Edge cases: in_number = 0 -> remainder 0, is_divisible 1, is_odd 0.
//   - MODULUS = 2: is_divisible == !is_odd for every input.
//   - WIDTH = 1: SHIFT lasts exactly 1 cycle.
// - No X propagation: every register has a reset value; default branches go to IDLE.
// STRUCTURE
// - Shared package num_analyzer_pkg: state encoding constants (IDLE=2'b00, SHIFT=2'b01,
//   DONE=2'b10) and the result-field width helper; reused by future analyzer variants.
// - One sub-module, mod_step: combinational (r, bit) -> (2r+bit) mod MODULUS, parameter MODULUS.
//   The top keeps the FSM, counter, shift register and handshakes.
// TESTING (WIDTH=8, MODULUS=3 unless noted)
// - Accept 8'd45 -> out_valid after 8 edges; is_odd 1, remainder 0, is_divisible 1.
// - Accept 8'd64 -> is_odd 0, remainder 1, is_divisible 0.
//   Accept 8'd255 -> is_odd 1, remainder 0, is_divisible 1.
// - Back-pressure: hold out_ready = 0 for 5 cycles in DONE -> outputs stable, in_ready 0;
//   release -> IDLE next edge, in_ready 1.
// - Drop enable after 3 SHIFT cycles on 8'd200 -> IDLE, out_valid never rises.
//   Re-enable and send 8'd7 -> remainder 1.
// - Assert reset mid-SHIFT -> all outputs 0 asynchronously; the next accepted 8'd9 gives
//   remainder 0, is_divisible 1.
// - MODULUS=2 and MODULUS=7, sweep 0..255 against a reference model:
//   remainder == n % MODULUS, is_divisible == (n % MODULUS == 0), is_odd == n[0].

Source files
------------

// File: rtl/num_analyzer_pkg.sv
// Shared definitions for the number-analyzer family: FSM encoding and result-width helper.
package num_analyzer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    // Bits needed to hold a value in 0..modulus-1.
    function automatic int rem_width(input int modulus);
        return (modulus <= 2) ? 1 : $clog2(modulus);
    endfunction

endpackage

// File: rtl/mod_step.sv
// One MSB-first step of serial modular reduction: r_next = (2*r + bit_in) mod MODULUS.
module mod_step
    import num_analyzer_pkg::*;
#(
    parameter int MODULUS = 3,
    localparam int RW = rem_width(MODULUS)
) (
    input  logic [RW-1:0] r,
    input  logic          bit_in,
    output logic [RW-1:0] r_next
);

    localparam logic [RW:0] MOD_T = MODULUS[RW:0];

    logic [RW:0] t;
    logic [RW:0] t_sub;

    // r < MODULUS bounds t below 2*MODULUS, so a single conditional subtract is exact.
    always_comb begin
        t      = {r, bit_in};
        t_sub  = t - MOD_T;
        r_next = (t >= MOD_T) ? t_sub[RW-1:0] : t[RW-1:0];
    end

endmodule

// File: rtl/parametric_number_analyzer.sv
// Serial odd/even, mod-MODULUS and divisibility classifier with valid/ready on both sides.
module parametric_number_analyzer
    import num_analyzer_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MODULUS = 3,
    localparam int RW = rem_width(MODULUS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_number,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             is_odd,
    output logic             is_divisible,
    output logic [RW-1:0]    remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    count;
    logic [RW-1:0]    r;
    logic [RW-1:0]    r_next;
    logic             last_bit;

    assign in_ready  = enable && (state == IDLE);
    assign out_valid = (state == DONE);
    assign last_bit  = (count == CW'(1));

    mod_step #(.MODULUS(MODULUS)) u_mod_step (
        .r      (r),
        .bit_in (shreg[WIDTH-1]),
        .r_next (r_next)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_valid) state_next = SHIFT;
                SHIFT:   if (last_bit) state_next = DONE;
                DONE:    if (out_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Result fields only move on the final shift, so they hold through back-pressure and aborts.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg        <= '0;
            count        <= '0;
            r            <= '0;
            is_odd       <= 1'b0;
            is_divisible <= 1'b0;
            remainder    <= '0;
        end else if (in_valid && in_ready) begin
            shreg  <= in_number;
            is_odd <= in_number[0];
            r      <= '0;
            count  <= CW'(WIDTH);
        end else if (enable && state == SHIFT) begin
            r     <= r_next;
            shreg <= shreg << 1;
            count <= count - CW'(1);
            if (last_bit) begin
                remainder    <= r_next;
                is_divisible <= (r_next == '0);
            end
        end
    end

endmodule
